sprite_fetch: RTL and testbench

SPRITE_FETCH -- requirements
Module: sprite_fetch

---
 rtl/sprite_fetch_pkg.sv | 46 ++++
 rtl/sprite_fetch_if.sv | 44 ++++
 rtl/sprite_slot_regs.sv | 30 +++
 rtl/sprite_fetch.sv | 165 ++++++++++++++++
 tb/tb_sprite_fetch.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_fetch_pkg.sv
// Shared definitions for the sprite fetch block: coordinate/colour widths,
// element codes, the element size table and the slot record layout.
package sprite_fetch_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned COLOUR_W = 12;

  // Palette value the sprite artwork uses for see-through pixels.
  localparam logic [COLOUR_W-1:0] TRANSPARENT_COLOUR = 12'hF0F;

  typedef enum logic [2:0] {
    EL_NONE = 3'd0,
    EL_1    = 3'd1,
    EL_2    = 3'd2,
    EL_3    = 3'd3,
    EL_4    = 3'd4,
    EL_5    = 3'd5,
    EL_6    = 3'd6,
    EL_7    = 3'd7
  } element_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic               active;
    logic [2:0]         element;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } slot_t;

  // Square sprite edge length per element; zero marks a non-fetchable element.
  function automatic logic [5:0] elem_size(input logic [2:0] el);
    case (el)
      EL_1, EL_2, EL_5: elem_size = 6'd25;
      EL_3:             elem_size = 6'd20;
      default:          elem_size = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/sprite_fetch_if.sv
// Pixel request, slot write, sprite memory and result signals of sprite_fetch.
interface sprite_fetch_if import sprite_fetch_pkg::*; #(
  parameter int unsigned SLOTS = 4
);
  localparam int unsigned IDX_W = $clog2(SLOTS);

  logic [COORD_W-1:0]  pixel_x;
  logic [COORD_W-1:0]  pixel_y;
  logic                pixel_valid;

  logic                wr_en;
  logic [IDX_W-1:0]    wr_slot;
  logic [COORD_W-1:0]  wr_x;
  logic [COORD_W-1:0]  wr_y;
  logic [2:0]          wr_element;
  logic                wr_active;

  logic                read_enable;
  logic [9:0]          address_sprite;
  logic [2:0]          element;
  logic [COLOUR_W-1:0] mem_data;

  logic [COLOUR_W-1:0] colour;
  logic                colour_valid;
  logic                hit;
  logic                busy;

  modport slave (
    input  pixel_x, pixel_y, pixel_valid,
    input  wr_en, wr_slot, wr_x, wr_y, wr_element, wr_active,
    input  mem_data,
    output read_enable, address_sprite, element,
    output colour, colour_valid, hit, busy
  );

  modport master (
    output pixel_x, pixel_y, pixel_valid,
    output wr_en, wr_slot, wr_x, wr_y, wr_element, wr_active,
    output mem_data,
    input  read_enable, address_sprite, element,
    input  colour, colour_valid, hit, busy
  );

endinterface

// File: rtl/sprite_slot_regs.sv
// Sprite slot register file: one write port, one combinational indexed read port.
module sprite_slot_regs import sprite_fetch_pkg::*; #(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned IDX_W = $clog2(SLOTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  slot_t            i_wr_slot,
  input  logic [IDX_W-1:0] i_rd_idx,
  output slot_t            o_rd_slot
);

  slot_t r_slots [SLOTS];

  // Slot storage; reset leaves every slot inactive at (0,0) with element 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        r_slots[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_slots[i_wr_idx] <= i_wr_slot;
    end
  end

  assign o_rd_slot = r_slots[i_rd_idx];

endmodule

// File: rtl/sprite_fetch.sv
// Resolves one pixel against the sprite slots: scans slots in ascending order,
// fetches the covering sprite texel and skips transparent texels.
module sprite_fetch import sprite_fetch_pkg::*; #(
  parameter int unsigned        SLOTS        = 4,
  parameter int unsigned        READ_LATENCY = 2,
  parameter logic [COLOUR_W-1:0] BG_COLOUR   = 12'h000,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = TRANSPARENT_COLOUR
) (
  input  logic          clk,
  input  logic          reset,
  sprite_fetch_if.slave bus
);

  localparam int unsigned       IDX_W     = $clog2(SLOTS);
  localparam int unsigned       WCNT_W    = $clog2(READ_LATENCY + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SLOTS - 1);
  localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(READ_LATENCY - 1);

  state_t              r_state;
  state_t              w_next;
  logic [IDX_W-1:0]    r_idx;
  logic [COORD_W-1:0]  r_px;
  logic [COORD_W-1:0]  r_py;
  logic [9:0]          r_addr;
  logic [2:0]          r_elem;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_hit;
  logic [WCNT_W-1:0]   r_wait;

  slot_t               w_wr_slot;
  slot_t               w_slot;
  logic [5:0]          w_size;
  logic [10:0]         w_end_x;
  logic [10:0]         w_end_y;
  logic [9:0]          w_dx;
  logic [9:0]          w_dy;
  logic [9:0]          w_addr;
  logic                w_hit;
  logic                w_last;
  logic                w_transparent;

  assign w_wr_slot = {bus.wr_active, bus.wr_element, bus.wr_x, bus.wr_y};

  sprite_slot_regs #(
    .SLOTS (SLOTS),
    .IDX_W (IDX_W)
  ) u_slots (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (bus.wr_en),
    .i_wr_idx  (bus.wr_slot),
    .i_wr_slot (w_wr_slot),
    .i_rd_idx  (r_idx),
    .o_rd_slot (w_slot)
  );

  // Coverage test uses 11-bit end coordinates so sprites near 1023 do not wrap.
  assign w_size        = elem_size(w_slot.element);
  assign w_end_x       = {1'b0, w_slot.x} + {5'b0, w_size};
  assign w_end_y       = {1'b0, w_slot.y} + {5'b0, w_size};
  assign w_dx          = r_px - w_slot.x;
  assign w_dy          = r_py - w_slot.y;
  assign w_addr        = w_dy * {4'b0, w_size} + w_dx;
  assign w_hit         = w_slot.active && (w_size != 6'd0)
                      && (r_px >= w_slot.x) && ({1'b0, r_px} < w_end_x)
                      && (r_py >= w_slot.y) && ({1'b0, r_py} < w_end_y);
  assign w_last        = (r_idx == LAST_IDX);
  assign w_transparent = (bus.mem_data == TRANSPARENT);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.pixel_valid) w_next = S_SCAN;
      S_SCAN: begin
        if (w_hit)       w_next = S_REQ;
        else if (w_last) w_next = S_DONE;
      end
      S_REQ:  w_next = S_WAIT;
      S_WAIT: begin
        if (r_wait == '0) begin
          if (!w_transparent || w_last) w_next = S_DONE;
          else                          w_next = S_SCAN;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded strobes.
  always_comb begin
    bus.read_enable  = 1'b0;
    bus.colour_valid = 1'b0;
    bus.busy         = 1'b1;
    case (r_state)
      S_IDLE: bus.busy         = 1'b0;
      S_REQ:  bus.read_enable  = 1'b1;
      S_DONE: bus.colour_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: pixel latch, slot index, fetch address, latency count and result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx    <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_addr   <= '0;
      r_elem   <= '0;
      r_colour <= BG_COLOUR;
      r_hit    <= 1'b0;
      r_wait   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.pixel_valid) begin
            r_px  <= bus.pixel_x;
            r_py  <= bus.pixel_y;
            r_idx <= '0;
          end
        end
        S_SCAN: begin
          if (w_hit) begin
            r_addr <= w_addr;
            r_elem <= w_slot.element;
          end else if (w_last) begin
            r_colour <= BG_COLOUR;
            r_hit    <= 1'b0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_REQ: r_wait <= WAIT_INIT;
        S_WAIT: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - WCNT_W'(1);
          end else if (!w_transparent) begin
            r_colour <= bus.mem_data;
            r_hit    <= 1'b1;
          end else if (w_last) begin
            r_colour <= BG_COLOUR;
            r_hit    <= 1'b0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.address_sprite = r_addr;
  assign bus.element        = r_elem;
  assign bus.colour         = r_colour;
  assign bus.hit            = r_hit;

endmodule

// File: tb/tb_sprite_fetch.sv
// Scoreboard bench for sprite_fetch: stimulus pushes expected reads/results,
// a negedge monitor models sprite memory and checks strobes as they appear.
module tb_sprite_fetch;
  import sprite_fetch_pkg::*;

  localparam int RL = 2;

  logic clk;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_pass;

  typedef struct { int colour; int hit; int due; } res_t;
  typedef struct { int addr; int el; int data; int due; } rd_t;

  res_t res_q[$];
  rd_t  rd_q[$];
  rd_t  stage_q[$];
  res_t r_res;
  rd_t  r_rd;
  bit   pend;
  int   pend_cyc;
  int   pend_data;

  sprite_fetch_if #(.SLOTS(4)) bus();

  sprite_fetch #(
    .SLOTS        (4),
    .READ_LATENCY (RL),
    .BG_COLOUR    (12'h000),
    .TRANSPARENT  (12'hF0F)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int want);
    n_chk++;
    if (act !== want) $display("FAIL %s: got %0h, want %0h", name, act, want);
    else n_pass++;
  endtask

  // Memory model and scoreboard monitor.
  always @(negedge clk) begin
    if (reset) begin
      pend = 1'b0;
      bus.mem_data = 12'hBAD;
    end else begin
      if (pend && cyc == pend_cyc + RL) begin
        bus.mem_data = pend_data[11:0];
        pend = 1'b0;
      end else begin
        bus.mem_data = 12'hBAD;
      end
      if (bus.read_enable) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_read", int'(bus.read_enable), 0);
        end else begin
          r_rd = rd_q.pop_front();
          chk("read_cycle", cyc, r_rd.due);
          chk("read_addr", int'(bus.address_sprite), r_rd.addr);
          chk("read_element", int'(bus.element), r_rd.el);
          pend = 1'b1;
          pend_cyc = cyc;
          pend_data = r_rd.data;
        end
      end
      if (bus.colour_valid) begin
        if (res_q.size() == 0) begin
          chk("unexpected_colour_valid", int'(bus.colour_valid), 0);
        end else begin
          r_res = res_q.pop_front();
          chk("result_cycle", cyc, r_res.due);
          chk("colour", int'(bus.colour), r_res.colour);
          chk("hit", int'(bus.hit), r_res.hit);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    bus.pixel_valid = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  task automatic drive_wr(input int slot, input int x, input int y, input int el, input int act);
    bus.wr_en = 1'b1;
    bus.wr_slot = slot[1:0];
    bus.wr_x = x[9:0];
    bus.wr_y = y[9:0];
    bus.wr_element = el[2:0];
    bus.wr_active = act[0];
  endtask

  task automatic write_slot(input int slot, input int x, input int y, input int el, input int act);
    step();
    drive_wr(slot, x, y, el, act);
  endtask

  task automatic add_read(input int addr, input int el, input int data, input int off);
    rd_t r;
    r.addr = addr; r.el = el; r.data = data; r.due = off;
    stage_q.push_back(r);
  endtask

  task automatic start_req(input int x, input int y, input bit push, input int c, input int h, input int lat);
    int t;
    res_t e;
    rd_t r;
    step();
    t = cyc;
    if (push) begin
      e.colour = c; e.hit = h; e.due = t + lat;
      res_q.push_back(e);
    end
    while (stage_q.size() > 0) begin
      r = stage_q.pop_front();
      r.due = r.due + t;
      rd_q.push_back(r);
    end
    bus.pixel_x = x[9:0];
    bus.pixel_y = y[9:0];
    bus.pixel_valid = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 64) begin
      step();
      n++;
    end
    if (bus.busy) chk("idle_timeout", int'(bus.busy), 0);
  endtask

  task automatic req(input int x, input int y, input int c, input int h, input int lat);
    start_req(x, y, 1'b1, c, h, lat);
    step();
    wait_idle();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_read_enable"}, int'(bus.read_enable), 0);
    chk({tag, "_colour_valid"}, int'(bus.colour_valid), 0);
    chk({tag, "_hit"}, int'(bus.hit), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_colour"}, int'(bus.colour), 'h000);
    chk({tag, "_address"}, int'(bus.address_sprite), 0);
    chk({tag, "_element"}, int'(bus.element), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; n_chk = 0; n_pass = 0; pend = 1'b0;
    reset = 1'b1;
    bus.pixel_x = '0; bus.pixel_y = '0; bus.pixel_valid = 1'b0;
    bus.wr_en = 1'b0; bus.wr_slot = '0; bus.wr_x = '0; bus.wr_y = '0;
    bus.wr_element = '0; bus.wr_active = 1'b0;
    bus.mem_data = 12'hBAD;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b0;

    // No active slots.
    req(0, 0, 'h000, 0, 5);

    // Single element-5 sprite, opaque texel.
    write_slot(0, 100, 50, 5, 1);
    add_read(77, 5, 'h0A5, 2);
    req(102, 53, 'h0A5, 1, 5);

    // Transparent in slot0, opaque in slot1.
    write_slot(1, 100, 50, 1, 1);
    add_read(77, 5, 'hF0F, 2);
    add_read(77, 1, 'h123, 6);
    req(102, 53, 'h123, 1, 9);

    // Non-fetchable element 4 covering the pixel.
    write_slot(0, 100, 50, 4, 1);
    write_slot(1, 0, 0, 0, 0);
    req(102, 53, 'h000, 0, 5);

    // Every covering sprite transparent, last slot included.
    write_slot(0, 100, 50, 5, 1);
    write_slot(3, 100, 50, 3, 1);
    add_read(77, 5, 'hF0F, 2);
    add_read(62, 3, 'hF0F, 8);
    req(102, 53, 'h000, 0, 11);

    // Right-edge boundary, then large-x no-wrap case.
    write_slot(3, 0, 0, 0, 0);
    write_slot(0, 100, 50, 2, 1);
    add_read(24, 2, 'h456, 2);
    req(124, 50, 'h456, 1, 5);
    req(125, 50, 'h000, 0, 5);
    write_slot(0, 1010, 0, 1, 1);
    add_read(13, 1, 'h789, 2);
    req(1023, 0, 'h789, 1, 5);

    // Slot write in the same cycle as the request.
    add_read(130, 1, 'h3C3, 2);
    start_req(5, 5, 1'b1, 'h3C3, 1, 5);
    drive_wr(0, 0, 0, 1, 1);
    step();
    wait_idle();

    // Write to a not-yet-scanned slot mid-request; pixel_valid while busy.
    write_slot(0, 0, 0, 0, 0);
    add_read(130, 5, 'h0F0, 4);
    start_req(5, 5, 1'b1, 'h0F0, 1, 7);
    step();
    drive_wr(2, 0, 0, 5, 1);
    step();
    bus.pixel_x = '0; bus.pixel_y = '0; bus.pixel_valid = 1'b1;
    step();
    wait_idle();

    // Reset during WAIT aborts without a result; slots are cleared.
    write_slot(0, 0, 0, 5, 1);
    add_read(26, 5, 'h555, 2);
    start_req(1, 1, 1'b0, 0, 0, 0);
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    step();
    reset = 1'b0;
    repeat (8) step();
    chk("post_reset_busy", int'(bus.busy), 0);
    req(1, 1, 'h000, 0, 5);

    repeat (3) step();
    chk("results_outstanding", res_q.size(), 0);
    chk("reads_outstanding", rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
